bscan_fifo_bridge: RTL

Parametrised BSCAN user-data-register bridge: a successor to the single-word BSCAN local block, with configurable word width, independent transmit and receive FIFOs, and frame-length checking. It sits between the BSCANE2/BUFG pair and the on-chip datapath. A host JTAG shift moves one word each way per DR scan. Words are committed only when the scan has exactly the frame length.

---
 rtl/bscan_pkg.sv | 15 +
 rtl/bscan_sync_fifo.sv | 52 +++++
 rtl/bscan_fifo_bridge.sv | 128 ++++++++++++
 3 files changed

// File: rtl/bscan_pkg.sv
// Shared sizing helpers for the BSCAN user-data-register bridge.
// Frame is payload plus one leading valid bit; the shift counter saturates at frame length + 1.
package bscan_pkg;

    localparam int STATS_W = 16;

    function automatic int frame_width(input int width);
        return width + 1;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width + 3);
    endfunction

endpackage

// File: rtl/bscan_sync_fifo.sv
// Single-clock circular FIFO with extra-MSB pointers; the head is visible combinationally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module bscan_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             i_enq_ena,
    input  logic [WIDTH-1:0] i_enq_v,
    output logic             o_enq_rdy,
    input  logic             i_deq_ena,
    output logic [WIDTH-1:0] o_deq_v,
    output logic             o_deq_rdy
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = i_deq_ena && !w_empty;
    assign w_push  = i_enq_ena && (!w_full || w_pop);

    assign o_enq_rdy = !w_full;
    assign o_deq_rdy = !w_empty;
    // Gate the head so an empty FIFO presents zeros rather than stale storage.
    assign o_deq_v   = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_enq_v;
    end

endmodule

// File: rtl/bscan_fifo_bridge.sv
// BSCAN DR bridge: one word each way per scan, committed only on an exact-length frame.
// Optional BSCAN_BRIDGE_STATS_EN adds saturating overflow/abort counters with a clear input.
module bscan_fifo_bridge
    import bscan_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic               CLK,
    input  logic               nRST,
`ifdef BSCAN_BRIDGE_STATS_EN
    input  logic               stats_clr,
    output logic [STATS_W-1:0] overflow_cnt,
    output logic [STATS_W-1:0] abort_cnt,
`endif
    input  logic               capture,
    input  logic               shift,
    input  logic               update,
    input  logic               TDI,
    output logic               TDO,
    input  logic               toBscan_enq__ENA,
    input  logic [WIDTH-1:0]   toBscan_enq_v,
    output logic               toBscan_enq__RDY,
    output logic               fromBscan_enq__ENA,
    output logic [WIDTH-1:0]   fromBscan_enq_v,
    input  logic               fromBscan_enq__RDY
);

    localparam int FRAME_W = frame_width(WIDTH);
    localparam int CNT_W   = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_GOOD = CNT_W'(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 2);

    logic [FRAME_W-1:0] r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_tx_sent;

    logic               w_tx_push;
    logic               w_tx_rdy;
    logic               w_tx_pop;
    logic               w_tx_vld;
    logic [WIDTH-1:0]   w_tx_head;
    logic               w_rx_push;
    logic               w_rx_rdy;
    logic               w_rx_pop;
    logic               w_rx_vld;
    logic               w_upd;
    logic               w_good;
    logic               w_abort;
    logic               w_overflow;

    // Capture wins over a coincident update, so an update only counts when capture is low.
    assign w_upd      = update && !capture;
    assign w_good     = w_upd && (r_cnt == CNT_GOOD);
    assign w_abort    = w_upd && !w_good;
    assign w_tx_push  = toBscan_enq__ENA && w_tx_rdy;
    assign w_tx_pop   = w_good && r_tx_sent;
    assign w_rx_push  = w_good && r_sr[0];
    assign w_rx_pop   = w_rx_vld && fromBscan_enq__RDY;
    assign w_overflow = w_rx_push && !w_rx_rdy && !w_rx_pop;

    assign TDO                = r_sr[0];
    assign toBscan_enq__RDY   = w_tx_rdy;
    assign fromBscan_enq__ENA = w_rx_pop;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_sr      <= '0;
            r_cnt     <= '0;
            r_tx_sent <= 1'b0;
        end else if (capture) begin
            r_sr      <= w_tx_vld ? {w_tx_head, 1'b1} : '0;
            r_cnt     <= '0;
            r_tx_sent <= w_tx_vld;
        end else if (!update && shift) begin
            r_sr <= {TDI, r_sr[FRAME_W-1:1]};
            if (r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
        end
    end

    bscan_sync_fifo #(.WIDTH(WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_enq_ena (w_tx_push),
        .i_enq_v   (toBscan_enq_v),
        .o_enq_rdy (w_tx_rdy),
        .i_deq_ena (w_tx_pop),
        .o_deq_v   (w_tx_head),
        .o_deq_rdy (w_tx_vld)
    );

    bscan_sync_fifo #(.WIDTH(WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .CLK       (CLK),
        .nRST      (nRST),
        .i_enq_ena (w_rx_push),
        .i_enq_v   (r_sr[FRAME_W-1:1]),
        .o_enq_rdy (w_rx_rdy),
        .i_deq_ena (w_rx_pop),
        .o_deq_v   (fromBscan_enq_v),
        .o_deq_rdy (w_rx_vld)
    );

`ifdef BSCAN_BRIDGE_STATS_EN
    logic [STATS_W-1:0] r_overflow_cnt;
    logic [STATS_W-1:0] r_abort_cnt;

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_overflow_cnt <= '0;
            r_abort_cnt    <= '0;
        end else if (stats_clr) begin
            r_overflow_cnt <= '0;
            r_abort_cnt    <= '0;
        end else begin
            if (w_overflow && (r_overflow_cnt != '1)) r_overflow_cnt <= r_overflow_cnt + 1'b1;
            if (w_abort && (r_abort_cnt != '1))       r_abort_cnt    <= r_abort_cnt + 1'b1;
        end
    end

    assign overflow_cnt = r_overflow_cnt;
    assign abort_cnt    = r_abort_cnt;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_overflow | w_abort;
`endif

endmodule
